param_muldiv_alu: RTL and testbench
===================================

// Module: param_muldiv_alu
// PURPOSE
//   Parametrised successor of the 32-bit execute-stage ALU cluster. Integrates
//   logic/arith/shift ops, a sequential shift-add MULTU, and a new restoring DIVU,
//   all writing a shared HI/LO pair. Adds valid/ready issue, out_valid completion
//   and an illegal-op flag. Sits between register read and writeback.
// PARAMETERS
//   WIDTH     32  datapath width in bits (>=8, power of 2)
//   SHW       5   shift-amount bits = log2(WIDTH)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low reset
//   in_valid   in   1      op request
//   in_ready   out  1      unit can accept (high only in IDLE)
//   dataA      in   WIDTH  operand A (shift source, dividend)
//   dataB      in   WIDTH  operand B (shift amount, divisor)
//   Signal     in   6      funct: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2,
//                          MULTU 25, DIVU 27, MFHI 16, MFLO 18
//   out_valid  out  1      1-cycle pulse: Output/illegal valid
//   Output     out  WIDTH  result (registered)
//   illegal    out  1      qualifies out_valid: unknown funct
// BEHAVIOUR
//   Reset (reset==0 at edge): FSM->IDLE, HI=LO=0, Output=0, out_valid=0,
//     illegal=0, counter=0. Applies mid-MULTU/DIVU: op aborted, no out_valid.
//   Accept = in_valid & in_ready at an edge; operands/Signal latched there.
//   FSM: IDLE -> (MULTU) MUL -> DONE -> IDLE; IDLE -> (DIVU) DIV -> DONE -> IDLE.
//     All other funct stay in IDLE.
//   Single-cycle ops: accepted at edge N -> out_valid=1, Output set after edge N;
//     back-to-back issue every cycle allowed.
//     AND/OR bitwise; ADD/SUB mod 2^WIDTH, no overflow trap;
//     SLT signed compare -> 1/0; SRL logical, amount = dataB[SHW-1:0];
//     MFHI/MFLO -> current HI/LO (incl. result of op completed previous cycle).
//   MULTU: unsigned WIDTHxWIDTH -> 2*WIDTH, one shift-add step/cycle, WIDTH steps
//     in MUL; DONE writes {HI,LO}=product, Output=LO, out_valid=1. Accept at N ->
//     out_valid after edge N+WIDTH+1. in_ready=0 from N+1 until back in IDLE.
//   DIVU: restoring, one quotient bit/cycle, WIDTH steps; LO=quotient,
//     HI=remainder, Output=LO, same latency as MULTU.
//     dataB==0: skip iteration, go DONE next cycle: LO=all-ones, HI=dataA.
//   Unknown funct: out_valid=1, illegal=1, Output=0, HI/LO unchanged.
//   HI/LO written only in DONE; single-cycle ops never modify them.
//   in_valid while busy: ignored (caller holds it; no queueing).
//   out_valid is a pulse; no output backpressure.
// STRUCTURE
//   Package alu_funct_pkg: 6-bit funct localparams, FSM state encoding
//     (IDLE/MUL/DIV/DONE), illegal-op code helper.
//   Sub-module seq_muldiv_core: WIDTH-param iterative mul/div datapath
//     (start, is_div, a, b -> done, hi, lo); top keeps FSM handshake, HI/LO,
//     combinational single-cycle result mux and the Output register.
// TESTING (WIDTH=32)
//   ADD 0xFFFFFFFF+1 -> Output 0, out_valid next cycle; SUB 5-7 -> 0xFFFFFFFE;
//     SLT -1,1 -> 1; SRL 0x80000000 by 35 -> 0x10000000 (amount 3).
//   MULTU 0xFFFFFFFF*0xFFFFFFFF -> out_valid exactly 33 cycles after accept,
//     HI=0xFFFFFFFE, LO=0x00000001; then MFHI next cycle -> 0xFFFFFFFE.
//   DIVU 100/7 -> LO=14, HI=2; DIVU 9/0 -> 1 cycle later LO=0xFFFFFFFF, HI=9.
//   in_valid held during MULTU -> in_ready=0, no extra out_valid; queued ADD
//     accepted the cycle after DONE.
//   reset low 10 cycles into DIVU -> no out_valid, HI=LO=0, in_ready=1 next cycle.
//   Signal=63 -> out_valid=1, illegal=1, Output=0, HI/LO unchanged.

Source files
------------

// File: rtl/alu_funct_pkg.sv
// Shared funct codes, FSM state encoding and op-legality helper for the muldiv ALU.
package alu_funct_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  // True for any funct this unit does not implement.
  function automatic logic is_illegal(input logic [5:0] f);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL,
      F_MULTU, F_DIVU, F_MFHI, F_MFLO: is_illegal = 1'b0;
      default:                         is_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
module seq_muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, is_div_q, is_div_d, done_q, done_d;
  logic [WIDTH:0]   mul_sum, div_tmp;

  // Load on start, then one mul/div step per busy cycle; done marks the final step.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    is_div_d = is_div_q;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_tmp  = {hi_q, lo_q[WIDTH-1]};
    if (start) begin
      is_div_d = is_div;
      cnt_d    = '0;
      if (is_div && (b == '0)) begin
        // Divide by zero skips iteration entirely.
        hi_d   = a;
        lo_d   = '1;
        busy_d = 1'b0;
      end else if (is_div) begin
        hi_d   = '0;
        lo_d   = a;
        m_d    = b;
        busy_d = 1'b1;
      end else begin
        hi_d   = '0;
        lo_d   = b;
        m_d    = a;
        busy_d = 1'b1;
      end
    end else if (busy_q) begin
      if (is_div_q) begin
        if (div_tmp >= {1'b0, m_q}) begin
          hi_d = WIDTH'(div_tmp - {1'b0, m_q});
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_tmp[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) busy_d = 1'b0;
    end
    done_d = busy_d && (cnt_d == CW'(WIDTH - 1));
  end

  // Datapath registers with synchronous abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/param_muldiv_alu.sv
// Execute-stage ALU: single-cycle ops plus iterative MULTU/DIVU sharing HI/LO.
module param_muldiv_alu
  import alu_funct_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             out_valid,
  output logic [WIDTH-1:0] Output,
  output logic             illegal
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, output_q, output_d;
  logic             out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, core_start, core_done;
  logic [WIDTH-1:0] core_hi, core_lo, alu_res;

  assign accept     = in_valid && in_ready_q;
  assign core_start = accept && ((Signal == F_MULTU) || (Signal == F_DIVU));

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (core_start),
    .is_div (Signal == F_DIVU),
    .a      (dataA),
    .b      (dataB),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Single-cycle result mux.
  always_comb begin
    alu_res = '0;
    case (Signal)
      F_AND:   alu_res = dataA & dataB;
      F_OR:    alu_res = dataA | dataB;
      F_ADD:   alu_res = dataA + dataB;
      F_SUB:   alu_res = dataA - dataB;
      F_SLT:   alu_res = ($signed(dataA) < $signed(dataB)) ? WIDTH'(1) : '0;
      F_SRL:   alu_res = dataA >> dataB[SHW-1:0];
      F_MFHI:  alu_res = hi_q;
      F_MFLO:  alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Issue/complete FSM; HI/LO only change when a mul/div retires.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    output_d    = output_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (Signal == F_MULTU) begin
            state_d = ST_MUL;
          end else if (Signal == F_DIVU) begin
            state_d = (dataB == '0) ? ST_DONE : ST_DIV;
          end else begin
            out_valid_d = 1'b1;
            illegal_d   = is_illegal(Signal);
            output_d    = is_illegal(Signal) ? '0 : alu_res;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (core_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        hi_d        = core_hi;
        lo_d        = core_lo;
        output_d    = core_lo;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      output_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      output_q    <= output_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Output    = output_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_param_muldiv_alu.sv
// Scoreboard bench for param_muldiv_alu at WIDTH=32.
module tb_param_muldiv_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic        out_valid;
  logic [31:0] Output;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  param_muldiv_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataA     (dataA),
    .dataB     (dataB),
    .Signal    (Signal),
    .out_valid (out_valid),
    .Output    (Output),
    .illegal   (illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference behaviour: plain arithmetic on the architectural HI/LO pair.
  task automatic model(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                       input int acc, output exp_t e);
    logic [63:0] p;
    logic [4:0]  sh;
    e.ill = 1'b0;
    e.cyc = acc;
    e.res = '0;
    sh    = b[4:0];
    case (s)
      6'd36: e.res = a & b;
      6'd37: e.res = a | b;
      6'd32: e.res = a + b;
      6'd34: e.res = a - b;
      6'd42: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:  e.res = a >> sh;
      6'd16: e.res = m_hi;
      6'd18: e.res = m_lo;
      6'd25: begin
        p     = {32'd0, a} * {32'd0, b};
        m_hi  = p[63:32];
        m_lo  = p[31:0];
        e.res = m_lo;
        e.cyc = acc + 33;
      end
      6'd27: begin
        if (b == 32'd0) begin
          m_hi  = a;
          m_lo  = 32'hFFFF_FFFF;
          e.cyc = acc + 1;
        end else begin
          m_lo  = a / b;
          m_hi  = a % b;
          e.cyc = acc + 33;
        end
        e.res = m_lo;
      end
      default: e.ill = 1'b1;
    endcase
  endtask

  // Present one request, hold it until accepted, push the expected response.
  task automatic issue(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                       output int acc);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    Signal   = s;
    dataA    = a;
    dataB    = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: in_ready stuck at 0 for funct %0d, required 1 within 200 cycles", s);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    model(s, a, b, acc, e);
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_out_valid: got Output %h at cycle %0d, required no output", Output, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (Output !== mon_e.res || illegal !== mon_e.ill || cyc != mon_e.cyc) begin
          n_err++;
          $display("FAIL result: got Output %h illegal %b cycle %0d, required Output %h illegal %b cycle %0d",
                   Output, illegal, cyc, mon_e.res, mon_e.ill, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc1, acc2, n;
    logic [5:0]  ops [12] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2,
                              6'd25, 6'd27, 6'd16, 6'd18, 6'd63, 6'd0};
    logic [5:0]  s;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_output", Output, 32'd0);
    reset = 1'b1;

    issue(6'd32, 32'hFFFF_FFFF, 32'd1, acc1);
    issue(6'd34, 32'd5, 32'd7, acc1);
    issue(6'd42, 32'hFFFF_FFFF, 32'd1, acc1);
    issue(6'd2, 32'h8000_0000, 32'd35, acc1);

    issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc1);
    @(negedge clk);
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    issue(6'd16, 32'd0, 32'd0, acc2);
    check("mfhi_after_done_cycle", 32'(acc2), 32'(acc1 + 34));
    issue(6'd18, 32'd0, 32'd0, acc2);

    issue(6'd25, 32'd12345, 32'd678, acc1);
    issue(6'd32, 32'd40, 32'd2, acc2);
    check("queued_add_cycle", 32'(acc2), 32'(acc1 + 34));

    issue(6'd27, 32'd100, 32'd7, acc1);
    issue(6'd16, 32'd0, 32'd0, acc2);
    issue(6'd18, 32'd0, 32'd0, acc2);
    issue(6'd27, 32'd9, 32'd0, acc1);
    issue(6'd16, 32'd0, 32'd0, acc2);
    check("div0_next_accept_cycle", 32'(acc2), 32'(acc1 + 2));
    issue(6'd18, 32'd0, 32'd0, acc2);

    issue(6'd63, 32'hDEAD_BEEF, 32'h1234_5678, acc1);
    issue(6'd16, 32'd0, 32'd0, acc2);
    issue(6'd18, 32'd0, 32'd0, acc2);

    // Abort a divide with reset partway through.
    issue(6'd27, 32'd100, 32'd7, acc1);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(negedge clk);
    issue(6'd16, 32'd0, 32'd0, acc2);
    issue(6'd18, 32'd0, 32'd0, acc2);

    for (int i = 0; i < 300; i++) begin
      s = ops[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'(1) << $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      issue(s, a, b, acc1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(sb.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
